// File: rtl/shift_r64_iter.sv
// Iterative 64-bit logical/arithmetic right shifter behind a valid/ready handshake.
// Resolves BITS_PER_CYCLE binary stages (32,16,8,4,2,1) per busy cycle; amounts >= 64 saturate.
module shift_r64_iter #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [7:0]  in_n,
    input  logic        in_arith,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);

    localparam int unsigned W          = 64;
    localparam int unsigned SW         = 6;
    localparam int unsigned NUM_STAGES = 6;
    localparam int unsigned CNT_W      = 3;
    localparam logic [W-1:0] ONES      = '1;

    // Only divisors of the stage count give a whole number of busy cycles.
    generate
        if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
              BITS_PER_CYCLE == 3 || BITS_PER_CYCLE == 6)) begin : g_bad_bpc
            $error("shift_r64_iter: BITS_PER_CYCLE must be 1, 2, 3 or 6");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       work_q, work_d;
    logic [SW-1:0]      n_q, n_d;
    logic               fill_q, fill_d;
    logic [CNT_W-1:0]   stage_q, stage_d;
    logic [W-1:0]       result_d;
    logic               fill_in;
    logic               sat_in;
    logic               zero_in;

    assign fill_in = in_arith & in_data[63];
    assign sat_in  = (in_n[7:6] != 2'b00);
    assign zero_in = (in_n == 8'd0);

    // Apply the stages [first, first+BITS_PER_CYCLE) whose n bit is set, inserting fill at the top.
    function automatic logic [W-1:0] apply_stages(
        input logic [W-1:0]     x,
        input logic [SW-1:0]    n,
        input logic             fill,
        input logic [CNT_W-1:0] first
    );
        logic [W-1:0] r;
        r = x;
        for (int s = 0; s < int'(NUM_STAGES); s++) begin
            if (s >= int'(first) && s < int'(first) + int'(BITS_PER_CYCLE) &&
                n[int'(SW) - 1 - s]) begin
                r = (r >> (32 >> s)) | (fill ? ~(ONES >> (32 >> s)) : '0);
            end
        end
        return r;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        n_d      = n_q;
        fill_d   = fill_q;
        stage_d  = stage_q;
        result_d = out_data;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    n_d     = in_n[SW-1:0];
                    fill_d  = fill_in;
                    stage_d = '0;
                    if (sat_in) begin
                        work_d   = {W{fill_in}};
                        result_d = {W{fill_in}};
                        state_d  = S_DONE;
                    end else if (zero_in) begin
                        work_d   = in_data;
                        result_d = in_data;
                        state_d  = S_DONE;
                    end else begin
                        work_d  = in_data;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                work_d  = apply_stages(work_q, n_q, fill_q, stage_q);
                stage_d = stage_q + CNT_W'(BITS_PER_CYCLE);
                if (int'(stage_q) + int'(BITS_PER_CYCLE) >= int'(NUM_STAGES)) begin
                    result_d = work_d;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q    <= '0;
            n_q       <= '0;
            fill_q    <= 1'b0;
            stage_q   <= '0;
            out_data  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            work_q    <= work_d;
            n_q       <= n_d;
            fill_q    <= fill_d;
            stage_q   <= stage_d;
            out_data  <= result_d;
            in_ready  <= (state_d == S_IDLE);
            out_valid <= (state_d == S_DONE);
            busy      <= (state_d != S_IDLE);
        end
    end

endmodule
